// File: rtl/line_fill_if.sv
// Bundle of signals between the cache controller, main memory and the line
// fill unit: miss request, victim data, memory beat bus and fill return.
interface line_fill_if #(
    parameter int ADDR_W = 20,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 8,
    parameter int TAG_W  = 7,
    parameter int IDX_W  = 7
);
    localparam int LINE_W = BEATS * BEAT_W;

    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_wb;
    logic [TAG_W-1:0]    victim_tag;
    logic [LINE_W-1:0]   victim_line;

    logic                mem_rd;
    logic                mem_wr;
    logic [ADDR_W-1:0]   mem_addr;
    logic [BEAT_W-1:0]   mem_wdata;
    logic [BEAT_W-1:0]   mem_rdata;
    logic                mem_ack;

    logic                fill_valid;
    logic [LINE_W-1:0]   fill_line;
    logic [TAG_W-1:0]    fill_tag;
    logic [IDX_W-1:0]    fill_index;
    logic                busy;

    // master: the line fill unit itself
    modport master (
        input  req_valid, req_addr, req_wb, victim_tag, victim_line,
        input  mem_rdata, mem_ack,
        output req_ready, mem_rd, mem_wr, mem_addr, mem_wdata,
        output fill_valid, fill_line, fill_tag, fill_index, busy
    );

    // slave: cache controller plus memory side
    modport slave (
        output req_valid, req_addr, req_wb, victim_tag, victim_line,
        output mem_rdata, mem_ack,
        input  req_ready, mem_rd, mem_wr, mem_addr, mem_wdata,
        input  fill_valid, fill_line, fill_tag, fill_index, busy
    );
endinterface

// File: rtl/line_fill_unit.sv
// Cache miss handler: optional 8-beat victim writeback, 8-beat block fetch,
// then a one-cycle fill pulse carrying the assembled line, tag and index.
module line_fill_unit #(
    parameter int ADDR_W = 20,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 8,
    parameter int IDX_W  = 7
) (
    input  logic        clk,
    input  logic        rst_b,
    line_fill_if.master bus
);
    localparam int WORD_W = $clog2(BEATS);
    localparam int BYTE_W = $clog2(BEAT_W / 8);
    localparam int OFF_W  = WORD_W + BYTE_W;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [WORD_W-1:0]   cnt_reg;
    logic [TAG_W-1:0]    tag_reg;
    logic [TAG_W-1:0]    victim_tag_reg;
    logic [IDX_W-1:0]    index_reg;
    logic [BEAT_W-1:0]   victim_words [BEATS];
    logic [BEAT_W-1:0]   line_words   [BEATS];

    logic                accept;
    logic                beat_done;
    logic                req_ready;
    logic                busy;
    logic                mem_rd;
    logic                mem_wr;
    logic                fill_valid;
    logic [ADDR_W-1:0]   mem_addr;
    logic [BEAT_W-1:0]   mem_wdata;

    // Block offset bits of the request address never reach the memory bus.
    logic unused_offset_bits;
    assign unused_offset_bits = &{1'b0, bus.req_addr[OFF_W-1:0]};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Outputs decode only from state and registers; mem_ack and req_* only
    // steer the next state and the register enables.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        beat_done  = 1'b0;
        req_ready  = 1'b0;
        busy       = 1'b1;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        fill_valid = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = bus.req_wb ? WB : RD;
                end
            end
            WB: begin
                mem_wr    = 1'b1;
                mem_addr  = {victim_tag_reg, index_reg, cnt_reg, {BYTE_W{1'b0}}};
                mem_wdata = victim_words[cnt_reg];
                if (bus.mem_ack) begin
                    beat_done = 1'b1;
                    if (cnt_reg == LAST_BEAT) begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                mem_rd   = 1'b1;
                mem_addr = {tag_reg, index_reg, cnt_reg, {BYTE_W{1'b0}}};
                if (bus.mem_ack) begin
                    beat_done = 1'b1;
                    if (cnt_reg == LAST_BEAT) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                fill_valid = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The counter wraps 7->0 naturally at the WB->RD handover.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_reg        <= '0;
            tag_reg        <= '0;
            victim_tag_reg <= '0;
            index_reg      <= '0;
        end else if (accept) begin
            cnt_reg        <= '0;
            tag_reg        <= bus.req_addr[ADDR_W-1 -: TAG_W];
            index_reg      <= bus.req_addr[OFF_W +: IDX_W];
            victim_tag_reg <= bus.victim_tag;
        end else if (beat_done) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
            logic [BEAT_W-1:0] victim_word_reg;
            logic [BEAT_W-1:0] line_word_reg;

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    victim_word_reg <= '0;
                end else if (accept) begin
                    victim_word_reg <= bus.victim_line[gi*BEAT_W +: BEAT_W];
                end
            end

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    line_word_reg <= '0;
                end else if (beat_done && state_reg == RD && cnt_reg == WORD_W'(gi)) begin
                    line_word_reg <= bus.mem_rdata;
                end
            end

            assign victim_words[gi]                     = victim_word_reg;
            assign line_words[gi]                       = line_word_reg;
            assign bus.fill_line[gi*BEAT_W +: BEAT_W]   = line_word_reg;
        end
    endgenerate

    assign bus.req_ready  = req_ready;
    assign bus.busy       = busy;
    assign bus.mem_rd     = mem_rd;
    assign bus.mem_wr     = mem_wr;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.fill_valid = fill_valid;
    assign bus.fill_tag   = tag_reg;
    assign bus.fill_index = index_reg;

endmodule

// File: tb/tb_line_fill_unit.sv
// Bench for line_fill_unit: memory responder with scoreboarded beats,
// table-driven miss requests and hand sequences for reset and back-to-back.
module tb_line_fill_unit;
    logic clk;
    logic rst_b;

    line_fill_if #(.ADDR_W(20), .BEAT_W(64), .BEATS(8), .TAG_W(7), .IDX_W(7)) bus ();

    line_fill_unit #(.ADDR_W(20), .BEAT_W(64), .BEATS(8), .IDX_W(7)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        logic [19:0] addr;
        logic        wb;
        logic [6:0]  vtag;
        logic [63:0] seed;
        logic        stall;
        logic [6:0]  exp_tag;
        logic [6:0]  exp_index;
        int          exp_base;
    } vec_t;

    beat_t        sb_q[$];
    logic [63:0]  mem_model [logic [19:0]];
    int           n_checks = 0;
    int           n_fail = 0;
    int           total_waits = 0;
    int           acks_seen = 0;
    bit           stall_en = 1'b0;
    logic [511:0] exp_line_g;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_read(input logic [19:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a, 12'hABC, ~a, 12'h5A5};
    endfunction

    function automatic logic [511:0] make_vline(input logic [63:0] seed);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = seed + 64'(k);
        return l;
    endfunction

    // Memory responder: random per-beat waits, stability and order checks.
    initial begin : responder
        int          waits_left;
        logic [19:0] held_addr;
        logic [63:0] held_wdata;
        beat_t       e;
        waits_left    = -1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                bus.mem_ack = 1'b0;
                waits_left  = -1;
            end else begin
                check("rd_wr_exclusive", {511'b0, bus.mem_rd & bus.mem_wr}, 512'b0);
                if (bus.mem_rd || bus.mem_wr) begin
                    if (waits_left < 0) begin
                        waits_left  = stall_en ? int'($urandom_range(0, 3)) : 0;
                        total_waits += waits_left;
                        held_addr   = bus.mem_addr;
                        held_wdata  = bus.mem_wdata;
                    end else begin
                        check("stall_addr_stable", bus.mem_addr, held_addr);
                        check("stall_wdata_stable", bus.mem_wdata, held_wdata);
                    end
                    if (waits_left == 0) begin
                        bus.mem_ack = 1'b1;
                        waits_left  = -1;
                        acks_seen++;
                        if (sb_q.size() == 0) begin
                            check("sb_underflow", 512'd1, 512'd0);
                        end else begin
                            e = sb_q.pop_front();
                            check("beat_kind", {511'b0, bus.mem_wr}, {511'b0, e.wr});
                            check("beat_addr", bus.mem_addr, e.addr);
                            if (e.wr) check("beat_wdata", bus.mem_wdata, e.data);
                        end
                        if (bus.mem_wr) mem_model[bus.mem_addr] = bus.mem_wdata;
                        else            bus.mem_rdata = mem_read(bus.mem_addr);
                    end else begin
                        bus.mem_ack   = 1'b0;
                        waits_left--;
                        bus.mem_rdata = {$urandom, $urandom};
                    end
                end else begin
                    // spurious acks while nothing is requested must be ignored
                    bus.mem_ack   = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
                    bus.mem_rdata = {$urandom, $urandom};
                end
            end
        end
    end

    // Drive a request at a negedge where req_ready is high; load the scoreboard.
    task automatic issue(input logic [19:0] addr, input logic wb, input logic [6:0] vtag,
                         input logic [511:0] vline);
        logic [6:0]  tag;
        logic [6:0]  idx;
        logic [19:0] a;
        beat_t       b;
        tag = addr[19:13];
        idx = addr[12:6];
        bus.req_valid   = 1'b1;
        bus.req_addr    = addr;
        bus.req_wb      = wb;
        bus.victim_tag  = vtag;
        bus.victim_line = vline;
        total_waits     = 0;
        if (wb) begin
            for (int k = 0; k < 8; k++) begin
                b.wr = 1'b1;
                b.addr = {vtag, idx, k[2:0], 3'b000};
                b.data = vline[64*k +: 64];
                sb_q.push_back(b);
            end
        end
        for (int k = 0; k < 8; k++) begin
            a = {tag, idx, k[2:0], 3'b000};
            b.wr = 1'b0;
            b.addr = a;
            b.data = '0;
            sb_q.push_back(b);
            exp_line_g[64*k +: 64] = (wb && vtag == tag) ? vline[64*k +: 64] : mem_read(a);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && !bus.req_ready; i++) @(negedge clk);
        if (!bus.req_ready) check("ready_timeout", 512'd0, 512'd1);
    endtask

    // Called at the negedge of cycle 1 after accept.
    task automatic wait_fill(input logic [6:0] etag, input logic [6:0] eidx, input int base,
                             output logic [511:0] line);
        int cyc;
        for (cyc = 1; cyc <= 400; cyc++) begin
            if (bus.fill_valid) break;
            @(negedge clk);
        end
        line = bus.fill_line;
        if (cyc > 400) begin
            check("fill_timeout", 512'd0, 512'd1);
            return;
        end
        check("fill_latency", cyc, base + total_waits);
        check("fill_tag", bus.fill_tag, etag);
        check("fill_index", bus.fill_index, eidx);
        check("fill_line", bus.fill_line, exp_line_g);
        check("sb_drained", sb_q.size(), 0);
        check("done_busy", {511'b0, bus.busy}, 512'd1);
        @(negedge clk);
        check("fill_pulse_width", {511'b0, bus.fill_valid}, 512'd0);
        check("ready_after_done", {511'b0, bus.req_ready}, 512'd1);
        check("fill_line_hold", bus.fill_line, exp_line_g);
    endtask

    task automatic run_txn(input vec_t v, output logic [511:0] line);
        @(negedge clk);
        wait_ready();
        stall_en = v.stall;
        issue(v.addr, v.wb, v.vtag, make_vline(v.seed));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid   = 1'b0;
        bus.req_addr    = 20'($urandom);
        bus.req_wb      = 1'($urandom);
        bus.victim_tag  = 7'($urandom);
        bus.victim_line = {16{$urandom}};
        wait_fill(v.exp_tag, v.exp_index, v.exp_base, line);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t         vecs[6];
        logic [511:0] line;
        logic [19:0]  a_addr;
        logic [19:0]  b_addr;
        logic [511:0] a_line;
        int           cyc;
        int           second;
        int           fills;
        int           start_acks;
        bit           spurious;

        vecs[0] = '{20'h0007A, 1'b0, 7'h00, 64'h0, 1'b0, 7'h00, 7'h01, 9};
        vecs[1] = '{20'h0207A, 1'b0, 7'h00, 64'h0, 1'b0, 7'h01, 7'h01, 9};
        vecs[2] = '{20'h240C0, 1'b1, 7'h55, 64'h0, 1'b0, 7'h12, 7'h03, 17};
        vecs[3] = '{20'hFFFFF, 1'b1, 7'h7F, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 7'h7F, 7'h7F, 17};
        vecs[4] = '{20'h00000, 1'b0, 7'h00, 64'h0, 1'b1, 7'h00, 7'h00, 9};
        vecs[5] = '{20'hABCDE, 1'b1, 7'h00, 64'hDEAD_BEEF_0000_0000, 1'b1, 7'h55, 7'h73, 17};

        for (int k = 0; k < 8; k++)
            mem_model[{7'd0, 7'd1, k[2:0], 3'b000}] = 64'h1111_1111_1111_1111 * 64'(k + 1);

        rst_b           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.req_wb      = 1'b0;
        bus.victim_tag  = '0;
        bus.victim_line = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {511'b0, bus.req_ready}, 512'd1);
        check("rst_busy", {511'b0, bus.busy}, 512'd0);
        check("rst_mem_rd", {511'b0, bus.mem_rd}, 512'd0);
        check("rst_mem_wr", {511'b0, bus.mem_wr}, 512'd0);
        check("rst_fill_valid", {511'b0, bus.fill_valid}, 512'd0);
        check("rst_mem_addr", bus.mem_addr, 512'd0);
        check("rst_mem_wdata", bus.mem_wdata, 512'd0);
        check("rst_fill_line", bus.fill_line, 512'd0);
        check("rst_fill_tag", bus.fill_tag, 512'd0);
        check("rst_fill_index", bus.fill_index, 512'd0);
        @(negedge clk);
        rst_b = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], line);
            $display("txn %0d addr=%h wb=%0b stall=%0b tag=%h idx=%h waits=%0d",
                     i, vecs[i].addr, vecs[i].wb, vecs[i].stall,
                     bus.fill_tag, bus.fill_index, total_waits);
            if (vecs[i].addr == 20'h0007A) begin
                check("fill_word0", line[63:0], 64'h1111_1111_1111_1111);
                check("fill_word7", line[511:448], 64'h8888_8888_8888_8888);
            end
            check("idle_mem_addr", bus.mem_addr, 512'd0);
        end

        // req_valid held high with a changing address across a whole fill
        stall_en = 1'b0;
        @(negedge clk);
        wait_ready();
        a_addr = 20'h3C5C0;
        issue(a_addr, 1'b0, 7'h00, 512'd0);
        a_line = exp_line_g;
        @(posedge clk);
        cyc = 0;
        second = 0;
        fills = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.fill_valid) begin
                fills++;
                check("held_fill_tag", bus.fill_tag, a_addr[19:13]);
                check("held_fill_index", bus.fill_index, a_addr[12:6]);
                check("held_fill_line", bus.fill_line, a_line);
            end
            if (bus.req_ready) begin
                second = cyc;
                break;
            end
            bus.req_addr = 20'($urandom);
        end
        check("held_fill_count", fills, 1);
        check("second_accept_cycle", second, 10);
        b_addr = 20'($urandom) & 20'hFFFC0;
        if (b_addr[19:6] == a_addr[19:6]) b_addr = b_addr ^ 20'h80000;
        issue(b_addr, 1'b0, 7'h00, 512'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_fill(b_addr[19:13], b_addr[12:6], 9, line);
        $display("txn held-valid first=%h second=%h accept_cycle=%0d", a_addr, b_addr, second);

        // reset in the middle of a fill after three read acks
        @(negedge clk);
        wait_ready();
        issue(20'h5A5C0, 1'b0, 7'h00, 512'd0);
        start_acks = acks_seen;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 50 && acks_seen < start_acks + 3; i++) @(negedge clk);
        check("mid_rd_acks", {511'b0, acks_seen >= start_acks + 3}, 512'd1);
        check("pre_reset_mem_rd", {511'b0, bus.mem_rd}, 512'd1);
        #2;
        rst_b = 1'b0;
        #1;
        check("async_rst_mem_rd", {511'b0, bus.mem_rd}, 512'd0);
        check("async_rst_busy", {511'b0, bus.busy}, 512'd0);
        check("async_rst_ready", {511'b0, bus.req_ready}, 512'd1);
        check("async_rst_mem_addr", bus.mem_addr, 512'd0);
        check("async_rst_fill_line", bus.fill_line, 512'd0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.fill_valid || bus.busy) spurious = 1'b1;
        end
        check("no_fill_after_reset", {511'b0, spurious}, 512'd0);
        $display("txn mid-rd reset acks_before_reset=%0d", acks_seen - start_acks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
